// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each operation takes three cycles: the grant cycle, an execute cycle, and a done cycle.
module alu_rr_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic             i_m0,
    input  logic [3:0]       i_s0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic             i_m1,
    input  logic [3:0]       i_s1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_done0,
    output logic             o_done1,
    output logic [WIDTH-1:0] o_res0,
    output logic [WIDTH-1:0] o_res1,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic             o_alu_m,
    output logic [3:0]       o_alu_s,
    input  logic [WIDTH-1:0] i_alu_f,
    output logic             o_busy,
    output logic [15:0]      o_op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_res0;
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_alu_m;
    logic [3:0]       r_alu_s;
    logic [15:0]      r_op_count;
    logic             w_gnt0;
    logic             w_gnt1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A lone requester always wins; ptr only breaks ties.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_gnt0 = i_req0 & (~i_req1 | ~r_ptr);
                w_gnt1 = i_req1 & (~i_req0 | r_ptr);
                if (w_gnt0 || w_gnt1) begin
                    w_state_next = StExec;
                end
            end
            StExec:  w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_res0     <= '0;
            r_res1     <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_m    <= 1'b0;
            r_alu_s    <= 4'h0;
            r_op_count <= 16'h0000;
        end else begin
            if (w_gnt0) begin
                r_alu_a <= i_a0;
                r_alu_b <= i_b0;
                r_alu_m <= i_m0;
                r_alu_s <= i_s0;
                r_owner <= 1'b0;
            end else if (w_gnt1) begin
                r_alu_a <= i_a1;
                r_alu_b <= i_b1;
                r_alu_m <= i_m1;
                r_alu_s <= i_s1;
                r_owner <= 1'b1;
            end
            // Capturing straight into the owner's result makes it visible during DONE.
            if (r_state == StExec) begin
                if (r_owner) begin
                    r_res1 <= i_alu_f;
                end else begin
                    r_res0 <= i_alu_f;
                end
            end
            if (r_state == StDone) begin
                r_ptr      <= ~r_owner;
                r_op_count <= r_op_count + 16'h0001;
            end
        end
    end

    assign o_gnt0     = w_gnt0;
    assign o_gnt1     = w_gnt1;
    assign o_done0    = (r_state == StDone) & ~r_owner;
    assign o_done1    = (r_state == StDone) & r_owner;
    assign o_res0     = r_res0;
    assign o_res1     = r_res1;
    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_m    = r_alu_m;
    assign o_alu_s    = r_alu_s;
    assign o_busy     = (r_state != StIdle);
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with an adder standing in for the ALU.
module tb_alu_rr_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req0 = 1'b0;
    logic [15:0] i_a0 = '0;
    logic [15:0] i_b0 = '0;
    logic        i_m0 = 1'b0;
    logic [3:0]  i_s0 = '0;
    logic        i_req1 = 1'b0;
    logic [15:0] i_a1 = '0;
    logic [15:0] i_b1 = '0;
    logic        i_m1 = 1'b0;
    logic [3:0]  i_s1 = '0;
    logic        o_gnt0, o_gnt1, o_done0, o_done1, o_alu_m, o_busy;
    logic [15:0] o_res0, o_res1, o_alu_a, o_alu_b, o_op_count, w_alu_f;
    logic [3:0]  o_alu_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    assign w_alu_f = o_alu_a + o_alu_b;

    alu_rr_arbiter #(.WIDTH(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_a0(i_a0), .i_b0(i_b0), .i_m0(i_m0), .i_s0(i_s0),
        .i_req1(i_req1), .i_a1(i_a1), .i_b1(i_b1), .i_m1(i_m1), .i_s1(i_s1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_done0(o_done0), .o_done1(o_done1),
        .o_res0(o_res0), .o_res1(o_res1),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_m(o_alu_m), .o_alu_s(o_alu_s),
        .i_alu_f(w_alu_f), .o_busy(o_busy), .o_op_count(o_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rst  = 1'b1;
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        // 1: reset values, then a single op from requester 0
        do_reset();
        #1;
        chk("rst_gnt", {o_gnt0, o_gnt1}, 0);
        chk("rst_done", {o_done0, o_done1}, 0);
        chk("rst_res", {o_res0, o_res1}, 0);
        chk("rst_cnt", o_op_count, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_alu", {o_alu_a, o_alu_b, o_alu_m, o_alu_s}, 0);
        @(negedge i_clk);
        i_req0 = 1'b1; i_a0 = 16'h5309; i_b0 = 16'h9546;
        #1;
        chk("t1_gnt0", {o_gnt0, o_gnt1, o_busy}, 3'b100);
        @(negedge i_clk);
        i_req0 = 1'b0;
        #1;
        chk("t1_exec", {o_gnt0, o_done0, o_busy}, 3'b001);
        chk("t1_alu_a", o_alu_a, 16'h5309);
        @(negedge i_clk); #1;
        chk("t1_done", {o_done0, o_done1, o_busy}, 3'b101);
        chk("t1_res0", o_res0, 16'hE84F);
        chk("t1_res1", o_res1, 16'h0000);
        @(negedge i_clk); #1;
        chk("t1_after", {o_done0, o_busy}, 2'b00);
        chk("t1_cnt", o_op_count, 16'h0001);
        chk("t1_hold", o_res0, 16'hE84F);

        // 2: both requesters held high alternate grants
        do_reset();
        i_req0 = 1'b1; i_a0 = 16'h0001; i_b0 = 16'h0001;
        i_req1 = 1'b1; i_a1 = 16'h0010; i_b1 = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge i_clk);
            #1;
            chk("t2_gnt", {o_gnt0, o_gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge i_clk); #1;
            chk("t2_exec", {o_gnt0, o_gnt1, o_done0, o_done1}, 0);
            @(negedge i_clk); #1;
            chk("t2_done", {o_done0, o_done1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 0) chk("t2_res0", o_res0, 16'h0002);
            else            chk("t2_res1", o_res1, 16'h0030);
        end
        @(negedge i_clk);
        i_req0 = 1'b0; i_req1 = 1'b0;
        #1;
        chk("t2_cnt", o_op_count, 16'h0004);
        chk("t2_idle", {o_gnt0, o_gnt1, o_busy}, 0);

        // 3: lone requester 1 granted back-to-back
        do_reset();
        i_req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge i_clk);
            #1;
            chk("t3_gnt", {o_gnt0, o_gnt1}, 2'b01);
            @(negedge i_clk); #1;
            chk("t3_exec", {o_gnt1, o_busy}, 2'b01);
            @(negedge i_clk);
            if (k == 2) i_req1 = 1'b0;
            #1;
            chk("t3_done", {o_done0, o_done1}, 2'b01);
            chk("t3_res1", o_res1, 16'h0030);
        end
        @(negedge i_clk); #1;
        chk("t3_cnt", o_op_count, 16'h0003);
        chk("t3_res0", o_res0, 16'h0000);
        chk("t3_idle", {o_gnt1, o_busy}, 0);

        // 4: operands latched at grant
        @(negedge i_clk);
        i_req0 = 1'b1; i_a0 = 16'h0002; i_b0 = 16'h0003;
        #1;
        chk("t4_gnt0", o_gnt0, 1);
        @(negedge i_clk);
        i_req0 = 1'b0; i_a0 = 16'hFFFF;
        #1;
        chk("t4_alu_a", o_alu_a, 16'h0002);
        @(negedge i_clk); #1;
        chk("t4_done", o_done0, 1);
        chk("t4_res0", o_res0, 16'h0005);
        @(negedge i_clk); #1;
        chk("t4_cnt", o_op_count, 16'h0004);

        // 5: reset during EXEC discards the operation
        i_req0 = 1'b1; i_a0 = 16'h0007; i_b0 = 16'h0001;
        #1;
        chk("t5_gnt0", o_gnt0, 1);
        @(negedge i_clk);
        i_req0 = 1'b0; i_rst = 1'b1;
        #1;
        chk("t5_exec", o_busy, 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("t5_nodone", {o_done0, o_done1, o_busy}, 0);
        chk("t5_res", {o_res0, o_res1}, 0);
        chk("t5_cnt", o_op_count, 0);
        i_req1 = 1'b1;
        #1;
        chk("t5_gnt1", {o_gnt0, o_gnt1}, 2'b01);
        @(negedge i_clk);
        i_req1 = 1'b0;
        @(negedge i_clk); #1;
        chk("t5_done1", {o_done0, o_done1}, 2'b01);
        chk("t5_res1", o_res1, 16'h0030);

        // 6: op_count wraps from 0xFFFF to 0x0000
        @(negedge i_clk);
        force dut.r_op_count = 16'hFFFF;
        @(negedge i_clk);
        release dut.r_op_count;
        #1;
        chk("t6_pre", o_op_count, 16'hFFFF);
        i_req0 = 1'b1; i_a0 = 16'h1000; i_b0 = 16'h0234;
        @(negedge i_clk);
        i_req0 = 1'b0;
        @(negedge i_clk); #1;
        chk("t6_done", o_done0, 1);
        chk("t6_res0", o_res0, 16'h1234);
        @(negedge i_clk); #1;
        chk("t6_wrap", o_op_count, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
